// File: rtl/match_pkg.sv
// Shared types and constants for the foosball match controller.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    PLAY,
    POINT,
    GAME_OVER
  } match_state_t;

  localparam int SCORE_W = 4;

  localparam logic SERVE_P1 = 1'b0;
  localparam logic SERVE_P2 = 1'b1;

  // Saturating score increment; the FSM never increments past the limit.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                  input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/start_debouncer.sv
// Start button conditioning: two-flop synchronizer, stable-level debounce,
// and a one-cycle pulse on the rising edge of the debounced level.
module start_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic start_game,
  output logic start_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= start_game;
      sync2 <= sync1;
      deb_d <= deb;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign start_pulse = deb & ~deb_d;

endmodule

// File: rtl/match_controller.sv
// Match sequencing for the foosball game: serve delay, rally gating,
// score keeping and game-over detection.
module match_controller
  import match_pkg::*;
#(
  parameter int WIN_SCORE          = 7,
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int SERVE_DELAY_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_game,
  input  logic               goal_left,
  input  logic               goal_right,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               play_enable,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  localparam int DW = (SERVE_DELAY_CYCLES > 1) ? $clog2(SERVE_DELAY_CYCLES) : 1;
  localparam logic [DW-1:0]      DLY_LAST = DW'(SERVE_DELAY_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  match_state_t       state, state_n;
  logic [SCORE_W-1:0] score1_n, score2_n;
  logic               serve_dir_n, winner_n;
  logic [DW-1:0]      dly, dly_n;
  logic               start_pulse;

  start_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk         (clk),
    .reset       (reset),
    .start_game  (start_game),
    .start_pulse (start_pulse)
  );

  always_comb begin
    state_n     = state;
    score1_n    = score1;
    score2_n    = score2;
    serve_dir_n = serve_dir;
    winner_n    = winner;
    dly_n       = dly;
    case (state)
      IDLE: begin
        if (start_pulse) begin
          score1_n = '0;
          score2_n = '0;
          dly_n    = '0;
          state_n  = SERVE_WAIT;
        end
      end
      SERVE_WAIT: begin
        if (dly == DLY_LAST) state_n = PLAY;
        else                 dly_n   = dly + DW'(1);
      end
      PLAY: begin
        // Simultaneous goals are treated as a void rally and re-served.
        if (goal_left && goal_right) begin
          dly_n   = '0;
          state_n = SERVE_WAIT;
        end else if (goal_right) begin
          score1_n    = sat_inc(score1, WIN);
          serve_dir_n = SERVE_P2;
          state_n     = POINT;
        end else if (goal_left) begin
          score2_n    = sat_inc(score2, WIN);
          serve_dir_n = SERVE_P1;
          state_n     = POINT;
        end
      end
      POINT: begin
        if (score1 == WIN) begin
          winner_n = 1'b0;
          state_n  = GAME_OVER;
        end else if (score2 == WIN) begin
          winner_n = 1'b1;
          state_n  = GAME_OVER;
        end else begin
          dly_n   = '0;
          state_n = SERVE_WAIT;
        end
      end
      GAME_OVER: begin
        if (start_pulse) begin
          score1_n    = '0;
          score2_n    = '0;
          serve_dir_n = SERVE_P1;
          dly_n       = '0;
          state_n     = SERVE_WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      score1      <= '0;
      score2      <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      dly         <= '0;
      play_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      score1      <= score1_n;
      score2      <= score2_n;
      serve_dir   <= serve_dir_n;
      winner      <= winner_n;
      dly         <= dly_n;
      play_enable <= (state_n == PLAY);
      game_over   <= (state_n == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: a cycle-level reference model feeds
// an expectation queue that a negedge monitor drains against the DUT.
module tb_match_controller;

  localparam int WIN = 3;
  localparam int DEB = 4;
  localparam int SD  = 8;

  logic       clk, reset, start_game, goal_left, goal_right;
  logic [3:0] score1, score2;
  logic       play_enable, serve_dir, game_over, winner;

  match_controller #(
    .WIN_SCORE(WIN), .DEBOUNCE_CYCLES(DEB), .SERVE_DELAY_CYCLES(SD)
  ) dut (
    .clk(clk), .reset(reset), .start_game(start_game),
    .goal_left(goal_left), .goal_right(goal_right),
    .score1(score1), .score2(score2), .play_enable(play_enable),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] s1, s2;
    logic pe, sd, go, w;
  } exp_t;

  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mst_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   prints = 0;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: game rules in plain terms, button seen through a
  // two-cycle sampling delay and a D-sample stability requirement.
  mst_t m_st;
  int   m_s1, m_s2, m_cnt, m_run;
  bit   m_dir, m_win, m_deb, m_rose, pulse, synced;
  bit   hist[$];

  function automatic exp_t cur_exp();
    exp_t e;
    e.s1 = 4'(m_s1);
    e.s2 = 4'(m_s2);
    e.pe = (m_st == M_PLAY);
    e.sd = m_dir;
    e.go = (m_st == M_OVER);
    e.w  = m_win;
    return e;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_st = M_IDLE; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_run = 0;
      m_dir = 0; m_win = 0; m_deb = 0; m_rose = 0;
      hist.delete();
      exp_q.delete();
      if (clk) exp_q.push_back(cur_exp());
    end else begin
      pulse = m_rose;
      case (m_st)
        M_IDLE: if (pulse) begin m_s1 = 0; m_s2 = 0; m_cnt = 0; m_st = M_SERVE; end
        M_SERVE: if (m_cnt == SD - 1) m_st = M_PLAY; else m_cnt++;
        M_PLAY: begin
          if (goal_left && goal_right) begin m_cnt = 0; m_st = M_SERVE; end
          else if (goal_right) begin m_s1 = (m_s1 < WIN) ? m_s1 + 1 : m_s1; m_dir = 1; m_st = M_POINT; end
          else if (goal_left) begin m_s2 = (m_s2 < WIN) ? m_s2 + 1 : m_s2; m_dir = 0; m_st = M_POINT; end
        end
        M_POINT: begin
          if (m_s1 == WIN) begin m_win = 0; m_st = M_OVER; end
          else if (m_s2 == WIN) begin m_win = 1; m_st = M_OVER; end
          else begin m_cnt = 0; m_st = M_SERVE; end
        end
        M_OVER: if (pulse) begin m_s1 = 0; m_s2 = 0; m_dir = 0; m_cnt = 0; m_st = M_SERVE; end
        default: m_st = M_IDLE;
      endcase
      synced = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(start_game);
      if (hist.size() > 4) void'(hist.pop_front());
      m_rose = 0;
      if (synced != m_deb) begin
        m_run++;
        if (m_run == DEB) begin m_deb = synced; m_run = 0; m_rose = synced; end
      end else begin
        m_run = 0;
      end
      exp_q.push_back(cur_exp());
    end
  end

  initial forever begin
    exp_t e, a;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {score1, score2, play_enable, serve_dir, game_over, winner};
      total++;
      if (a !== e) begin
        bad++;
        if (prints < 30)
          $display("FAIL scoreboard t=%0t got s1=%0d s2=%0d pe=%b sd=%b go=%b w=%b expected s1=%0d s2=%0d pe=%b sd=%b go=%b w=%b",
                   $time, a.s1, a.s2, a.pe, a.sd, a.go, a.w, e.s1, e.s2, e.pe, e.sd, e.go, e.w);
        prints++;
      end
    end
  end

  task automatic wait_play();
    int k = 0;
    while (!play_enable && k < 200) begin @(negedge clk); k++; end
    if (!play_enable) check("wait_play_timeout", 0, 1);
  endtask

  task automatic count_to_play(output int k);
    k = 0;
    while (!play_enable && k < 200) begin @(negedge clk); k++; end
  endtask

  task automatic goal(input bit l, input bit r);
    goal_left = l; goal_right = r;
    @(negedge clk);
    goal_left = 0; goal_right = 0;
  endtask

  initial begin
    int k, btn_left;
    reset = 0; start_game = 0; goal_left = 0; goal_right = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("reset_s1", int'(score1), 0);
    check("reset_pe", int'(play_enable), 0);

    // Clean press: pulse at rise+6, then SD cycles of serve wait.
    start_game = 1;
    count_to_play(k);
    check("start_to_play_cycles", k, 2 + DEB + 1 + SD);
    repeat (6) @(negedge clk);
    start_game = 0;
    repeat (8) @(negedge clk);
    check("start_scores", int'(score1) + int'(score2), 0);

    // Short glitch during play is filtered.
    start_game = 1;
    repeat (DEB - 1) @(negedge clk);
    start_game = 0;
    repeat (12) @(negedge clk);
    check("glitch_keeps_play", int'(play_enable), 1);

    wait_play();
    goal(0, 1);
    check("goal_r_s1", int'(score1), 1);
    check("goal_r_pe", int'(play_enable), 0);
    check("goal_r_dir", int'(serve_dir), 1);
    count_to_play(k);
    check("goal_r_resume", k, 1 + SD);

    goal(1, 1);
    check("both_s1", int'(score1), 1);
    check("both_s2", int'(score2), 0);
    check("both_dir", int'(serve_dir), 1);
    check("both_pe", int'(play_enable), 0);
    count_to_play(k);
    check("both_resume", k, SD);

    for (int i = 0; i < 3; i++) begin
      wait_play();
      goal(1, 0);
    end
    @(negedge clk);
    check("over_s2", int'(score2), WIN);
    check("over_go", int'(game_over), 1);
    check("over_win", int'(winner), 1);
    check("over_pe", int'(play_enable), 0);
    goal(1, 0);
    goal(0, 1);
    @(negedge clk);
    check("over_hold_s1", int'(score1), 1);
    check("over_hold_s2", int'(score2), WIN);
    start_game = 1;
    repeat (8) @(negedge clk);
    start_game = 0;
    k = 0;
    while (game_over && k < 100) begin @(negedge clk); k++; end
    check("restart_go", int'(game_over), 0);
    check("restart_scores", int'(score1) + int'(score2), 0);
    check("restart_dir", int'(serve_dir), 0);
    repeat (8) @(negedge clk);

    // Asynchronous reset in serve wait with score1=2.
    wait_play(); goal(0, 1);
    wait_play(); goal(0, 1);
    repeat (2) @(negedge clk);
    check("pre_reset_s1", int'(score1), 2);
    #2 reset = 0;
    #1;
    check("async_s1", int'(score1), 0);
    check("async_s2", int'(score2), 0);
    check("async_pe", int'(play_enable), 0);
    check("async_dir", int'(serve_dir), 0);
    check("async_go", int'(game_over), 0);
    check("async_win", int'(winner), 0);
    repeat (3) @(negedge clk);
    reset = 1;
    goal(0, 1);
    goal(1, 0);
    @(negedge clk);
    check("idle_ignores_goal", int'(score1) + int'(score2), 0);

    // Randomized play: goals at any time, presses of random length.
    btn_left = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      goal_left  = ($urandom_range(0, 19) == 0);
      goal_right = ($urandom_range(0, 19) == 0);
      if (btn_left > 0) begin
        btn_left--;
        if (btn_left == 0) start_game = 0;
      end else if ($urandom_range(0, 59) == 0) begin
        start_game = 1;
        btn_left = $urandom_range(1, 12);
      end
    end
    goal_left = 0; goal_right = 0; start_game = 0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Game-flow controller sitting upstream of the foosball top-level's score display and alongside its graphics generator.
- Conditions the raw start_game button.
- Consumes goal events from the graphics generator, keeps both scores, and gates ball motion through play_enable.
- Sequences the match: idle, serve delay, rally, point, game over.

Parameters:
- WIN_SCORE, 7, score that ends the match (legal range 1..9, single seven-segment digit)
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a new button level (>=2)
- SERVE_DELAY_CYCLES, 50000000, clk cycles spent in SERVE_WAIT before play resumes (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start_game  input  1  raw push-button, asynchronous to clk
- goal_left  input  1  one-cycle pulse: ball entered left goal (player 2 scores)
- goal_right  input  1  one-cycle pulse: ball entered right goal (player 1 scores)
- score1  output  4  player 1 score, unsigned
- score2  output  4  player 2 score, unsigned
- play_enable  output  1  high only in PLAY; ball motion frozen when low
- serve_dir  output  1  0 = serve toward player 1, 1 = toward player 2
- game_over  output  1  high only in GAME_OVER
- winner  output  1  0 = player 1, 1 = player 2; valid while game_over

Behaviour:
- Reset (reset=0, asynchronous) forces the following; synchronizer and debounce state also clear:
  - state IDLE
  - score1 = score2 = 0
  - play_enable = 0, serve_dir = 0, game_over = 0, winner = 0
  - internal delay counter = 0
- Start conditioning:
  - Two-flop synchronizer, then a debounce counter.
  - When the synced level differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level updates and the counter clears. Any return to equality clears the counter.
  - start_pulse = one-cycle rising edge of the debounced level.
  - Raw rise held stable: start_pulse is high in cycle 2+DEBOUNCE_CYCLES after the rise.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER.
  - IDLE: start_pulse -> clear scores, delay counter = 0, go to SERVE_WAIT.
  - SERVE_WAIT:
    - Counter increments each cycle.
    - When counter == SERVE_DELAY_CYCLES-1, go to PLAY next cycle.
    - Goals and start_pulse are ignored.
  - PLAY:
    - goal_right alone: score1 += 1, serve_dir <= 1, go to POINT.
    - goal_left alone: score2 += 1, serve_dir <= 0, go to POINT.
    - Both in the same cycle: no score change, serve_dir unchanged, go to SERVE_WAIT with counter = 0.
    - start_pulse is ignored.
  - POINT (exactly 1 cycle):
    - If score1 == WIN_SCORE: winner <= 0, go to GAME_OVER.
    - Else if score2 == WIN_SCORE: winner <= 1, go to GAME_OVER.
    - Else go to SERVE_WAIT with counter = 0.
  - GAME_OVER: scores held; start_pulse -> clear scores, serve_dir <= 0, go to SERVE_WAIT.
- Latency and output rules:
  - A goal pulse at cycle N gives the updated score and play_enable = 0 at N+1.
  - play_enable, game_over: registered, decoded from the state.
  - Scores never exceed WIN_SCORE; an increment at WIN_SCORE is unreachable by construction, and saturates if forced.
  - Goal pulses outside PLAY are dropped, not queued.
  - Reset mid-rally returns to IDLE immediately; scores are lost.

Decomposition:
- Package match_pkg:
  - typedef enum logic [2:0] match_state_t {IDLE, SERVE_WAIT, PLAY, POINT, GAME_OVER}
  - localparam SCORE_W = 4
  - SERVE_P1 = 1'b0, SERVE_P2 = 1'b1
- Sub-module start_debouncer (synchronizer + debounce counter + edge detect) with parameter DEBOUNCE_CYCLES; output start_pulse.
- The FSM and score registers stay in match_controller.

Test Plan (WIN_SCORE=3, DEBOUNCE_CYCLES=4, SERVE_DELAY_CYCLES=8):
1. Reset, then start_game high for 20 cycles -> start_pulse exactly once, 6 cycles after the rise; play_enable rises 8 cycles after leaving IDLE; scores 0/0.
2. In PLAY, start_game pulses high for 3 cycles -> no start_pulse, state unchanged.
3. In PLAY, goal_right pulse -> next cycle score1=1, play_enable=0, serve_dir=1; play_enable back high 1+8 cycles later.
4. goal_left and goal_right in the same cycle -> scores unchanged, serve_dir unchanged, SERVE_WAIT, play resumes after 8 cycles.
5. Three goal_left pulses, each in PLAY -> score2=3, game_over=1, winner=1, play_enable stays 0. Further goal pulses: no change. A debounced start press -> scores 0/0, serve_dir=0, SERVE_WAIT.
6. Assert reset=0 mid-SERVE_WAIT with score1=2 -> all outputs at reset values in the same cycle, asynchronously. After release, state IDLE, and goal pulses are ignored.
